// File: rtl/rc4_keystream_if.sv
// Write port between the RC4 keystream generator and the downstream byte FIFO.
interface rc4_keystream_if;
    logic       wr_fifo;
    logic [7:0] wr_data;
    logic       full;

    modport master (output wr_fifo, output wr_data, input full);
    modport slave  (input wr_fifo, input wr_data, output full);
endinterface

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: latches a key, runs KSA over a 256-byte S-box,
// then emits one PRGA byte per GEN->HOLD step into the downstream FIFO.
module rc4_keystream #(
    parameter int KEY_BYTES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [8*KEY_BYTES-1:0]         key,
    input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
    input  logic                           gen_en,
    output logic                           busy,
    output logic                           ready,
    rc4_keystream_if.master                wr
);
    localparam int LW = $clog2(KEY_BYTES + 1);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, INIT, KSA, GEN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d, data_q, data_d;
    logic [KW-1:0] k_q, k_d, klast_q, klast_d;
    logic [7:0]    key_q [KEY_BYTES];
    logic [7:0]    key_d [KEY_BYTES];
    logic [7:0]    sbox  [256];

    // Two write ports are enough for every state: INIT writes one entry, KSA/GEN swap two.
    logic          s_we;
    logic [7:0]    wa_addr, wa_data, wb_addr, wb_data;

    logic [7:0]    ip, ksa_j, gen_j, gen_t, gen_out;

    // Combinational S-box reads feeding KSA and PRGA arithmetic (all mod 256).
    always_comb begin
        ip    = i_q + 8'd1;
        ksa_j = j_q + sbox[i_q] + key_q[k_q];
        gen_j = j_q + sbox[ip];
        gen_t = sbox[ip] + sbox[gen_j];
        // The swap lands on the same edge, so forward the post-swap value of S[t].
        if (gen_t == ip)
            gen_out = sbox[gen_j];
        else if (gen_t == gen_j)
            gen_out = sbox[ip];
        else
            gen_out = sbox[gen_t];
    end

    // Next-state, counter and S-box write decode for the five-state sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        klast_d = klast_q;
        data_d  = data_q;
        key_d   = key_q;
        s_we    = 1'b0;
        wa_addr = i_q;
        wa_data = i_q;
        wb_addr = i_q;
        wb_data = i_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int n = 0; n < KEY_BYTES; n++)
                        key_d[n] = key[8*n +: 8];
                    if (key_len == '0 || key_len > LW'(KEY_BYTES))
                        klast_d = KW'(KEY_BYTES - 1);
                    else
                        klast_d = KW'(key_len - LW'(1));
                    i_d     = 8'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_we = 1'b1;
                i_d  = ip;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = KSA;
                end
            end
            KSA: begin
                s_we    = 1'b1;
                wa_addr = i_q;
                wa_data = sbox[ksa_j];
                wb_addr = ksa_j;
                wb_data = sbox[i_q];
                i_d     = ip;
                j_d     = ksa_j;
                k_d     = (k_q == klast_q) ? '0 : k_q + KW'(1);
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (gen_en) begin
                    s_we    = 1'b1;
                    wa_addr = ip;
                    wa_data = sbox[gen_j];
                    wb_addr = gen_j;
                    wb_data = sbox[ip];
                    i_d     = ip;
                    j_d     = gen_j;
                    data_d  = gen_out;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!wr.full)
                    state_d = GEN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched key and held output byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= '0;
            klast_q <= '0;
            data_q  <= 8'd0;
            for (int n = 0; n < KEY_BYTES; n++)
                key_q[n] <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            klast_q <= klast_d;
            data_q  <= data_d;
            key_q   <= key_d;
        end
    end

    // S-box swap writes; when both addresses match both ports carry the same value.
    // NOTE: the S-box is not reset; INIT rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (s_we) begin
            sbox[wa_addr] <= wa_data;
            sbox[wb_addr] <= wb_data;
        end
    end

    assign busy       = (state_q == INIT) || (state_q == KSA);
    assign ready      = (state_q == GEN)  || (state_q == HOLD);
    assign wr.wr_fifo = (state_q == HOLD);
    assign wr.wr_data = data_q;
endmodule

// File: tb/tb_rc4_keystream.sv
// Directed bench for rc4_keystream: known RC4 vectors, latency, backpressure,
// generation pause, ignored start pulses, async reset, and key_len=0 handling.
module tb_rc4_keystream;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [4:0]   key_len = '0;
    logic         gen_en = 1'b1;
    logic         busy, ready;

    logic         start3 = 1'b0;
    logic [23:0]  key3 = '0;
    logic [1:0]   key_len3 = '0;
    logic         gen_en3 = 1'b1;
    logic         busy3, ready3;

    rc4_keystream_if wr_a ();
    rc4_keystream_if wr_b ();

    rc4_keystream #(.KEY_BYTES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_len(key_len),
        .gen_en(gen_en), .busy(busy), .ready(ready), .wr(wr_a)
    );

    rc4_keystream #(.KEY_BYTES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .key(key3), .key_len(key_len3),
        .gen_en(gen_en3), .busy(busy3), .ready(ready3), .wr(wr_b)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_K  = 128'h79_65_4B;
    localparam logic [127:0] KEY_W  = 128'h69_6B_69_57;
    localparam logic [127:0] KEY_S  = 128'h74_65_72_63_65_53;
    localparam logic [7:0] EXP_K [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                                          8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    localparam logic [7:0] EXP_W [6]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    localparam logic [7:0] EXP_S [8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05,
                                          8'h3C, 8'hA8, 8'h7B, 8'h59};

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] got_q [$];
    logic [7:0] got3_q [$];

    // Inputs only change at posedge+1, so a negedge view of wr_fifo && !full
    // is exactly the set of transfers on the following edge.
    always @(negedge clk) begin
        if (rst_n && wr_a.wr_fifo && !wr_a.full) got_q.push_back(wr_a.wr_data);
        if (rst_n && wr_b.wr_fifo && !wr_b.full) got3_q.push_back(wr_b.wr_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int n);
        if (n < got_q.size()) return {24'd0, got_q[n]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pulse start and count edges (start edge = 1) until ready is seen;
    // optionally re-pulse start at edge repulse_at.
    task automatic run_start(input logic [127:0] k, input logic [4:0] len,
                             input int repulse_at, output int edges, output logic busy1);
        key = k;
        key_len = len;
        start = 1'b1;
        edges = 0;
        busy1 = 1'b0;
        while (edges < 2000) begin
            tick();
            edges++;
            if (edges == 1) busy1 = busy;
            start = (edges == repulse_at);
            if (ready) break;
        end
        start = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got_q.size() < n && c < 400) begin
            tick();
            c++;
        end
        if (got_q.size() < n) check("timeout_bytes", got_q.size(), n);
    endtask

    initial begin
        int   edges;
        logic b1;
        int   bad;
        int   c;

        // Reset state, observed while reset is still asserted.
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_wr_fifo", wr_a.wr_fifo, 0);
        check("rst_wr_data", wr_a.wr_data, 0);
        wr_a.full = 1'b0;
        wr_b.full = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // "Key": latency, first byte, backpressure, pause, ignored start in GEN.
        got_q.delete();
        run_start(KEY_K, 5'd3, 0, edges, b1);
        check("key_busy_after_e0", b1, 1);
        check("key_ready_latency", edges, 513);
        check("key_busy_at_ready", busy, 0);
        check("key_gen_no_wr", wr_a.wr_fifo, 0);
        tick();
        check("key_first_wr_fifo", wr_a.wr_fifo, 1);
        check("key_first_wr_data", wr_a.wr_data, 32'hEB);

        wait_got(2);
        wr_a.full = 1'b1;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (wr_a.wr_fifo !== 1'b1 || wr_a.wr_data !== 8'h77) bad++;
        end
        check("bp_hold_stable", bad, 0);
        check("bp_no_transfer", got_q.size(), 2);
        wr_a.full = 1'b0;

        wait_got(5);
        gen_en = 1'b0;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            start = (n == 3);
            key = KEY_W;
            tick();
            if (wr_a.wr_fifo !== 1'b0 || wr_a.wr_data !== 8'hB7) bad++;
        end
        start = 1'b0;
        check("pause_no_wr", bad, 0);
        check("pause_count", got_q.size(), 5);
        gen_en = 1'b1;

        wait_got(10);
        for (int n = 0; n < 10; n++)
            check($sformatf("key_byte%0d", n), byte_at(n), {24'd0, EXP_K[n]});

        // Async reset while a byte is held under backpressure.
        wr_a.full = 1'b1;
        c = 0;
        while (!wr_a.wr_fifo && c < 10) begin
            tick();
            c++;
        end
        check("hold_reached", wr_a.wr_fifo, 1);
        rst_n = 1'b0;
        #1;
        check("hold_rst_wr_fifo", wr_a.wr_fifo, 0);
        check("hold_rst_wr_data", wr_a.wr_data, 0);
        check("hold_rst_ready", ready, 0);
        tick();
        rst_n = 1'b1;
        wr_a.full = 1'b0;
        tick();
        tick();
        check("post_rst_no_wr", wr_a.wr_fifo, 0);
        check("post_rst_count", got_q.size(), 10);

        // Async reset in the middle of KSA.
        key = KEY_K;
        key_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) tick();
        check("ksa_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("ksa_rst_busy", busy, 0);
        check("ksa_rst_ready", ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // "Key" again with start re-pulsed during KSA.
        got_q.delete();
        run_start(KEY_K, 5'd3, 400, edges, b1);
        check("rekey_ignored_latency", edges, 513);
        wait_got(3);
        for (int n = 0; n < 3; n++)
            check($sformatf("rekey_byte%0d", n), byte_at(n), {24'd0, EXP_K[n]});

        // "Wiki".
        pulse_reset();
        got_q.delete();
        run_start(KEY_W, 5'd4, 0, edges, b1);
        wait_got(6);
        for (int n = 0; n < 6; n++)
            check($sformatf("wiki_byte%0d", n), byte_at(n), {24'd0, EXP_W[n]});

        // "Secret".
        pulse_reset();
        got_q.delete();
        run_start(KEY_S, 5'd6, 0, edges, b1);
        wait_got(8);
        for (int n = 0; n < 8; n++)
            check($sformatf("secret_byte%0d", n), byte_at(n), {24'd0, EXP_S[n]});

        // key_len=0 on a KEY_BYTES=3 instance behaves as length 3.
        pulse_reset();
        got3_q.delete();
        key3 = 24'h79_65_4B;
        key_len3 = 2'd0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        c = 0;
        while (got3_q.size() < 3 && c < 1000) begin
            tick();
            c++;
        end
        check("len0_count", got3_q.size(), 3);
        for (int n = 0; n < 3; n++)
            check($sformatf("len0_byte%0d", n),
                  (n < got3_q.size()) ? {24'd0, got3_q[n]} : 32'hFFFF_FFFF,
                  {24'd0, EXP_K[n]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
